// File: rtl/arb_pkg.sv
// Shared types and sizing for the round-robin mux/demux arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               ptr,
    output logic               any,
    output sel_t               win
);

    sel_t               start;
    sel_t               off;
    logic [NUM_REQ-1:0] rot;

    always_comb begin
        start = ptr + 3'd1;
        // Rotate so the bit just after ptr lands at position 0.
        rot   = NUM_REQ'({req, req} >> start);
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = sel_t'(i);
        end
        any = |req;
        win = off + start;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 mux/demux channel.
// Define ARB_TIMEOUT_EN to bound each grant to TIMEOUT_CYCLES cycles with a preempt pulse.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic [SEL_W-1:0]   sel,
    output logic               preempt
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    arb_state_t state;
    sel_t       ptr;
    logic       pick_any;
    sel_t       pick_win;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .win (pick_win)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            sel     <= '0;
            ptr     <= 3'd7;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= GRANT;
                        gnt     <= 8'd1 << pick_win;
                        gnt_vld <= 1'b1;
                        sel     <= pick_win;
                        ptr     <= pick_win;
                        cnt     <= '0;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                    end else if (cnt == TimeoutLast) begin
                        // ptr already names this owner, so it loses the next arbitration.
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                        preempt <= 1'b1;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign preempt = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            sel     <= '0;
            ptr     <= 3'd7;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= GRANT;
                        gnt     <= 8'd1 << pick_win;
                        gnt_vld <= 1'b1;
                        sel     <= pick_win;
                        ptr     <= pick_win;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter (both ARB_TIMEOUT_EN builds).
module tb_rr_mux_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic [2:0] sel;
    logic       preempt;

    int n_asrt;
    int n_fail;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    rr_mux_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .sel     (sel),
        .preempt (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eg, input logic [2:0] es,
                              input logic ep);
        check({tag, ".gnt"}, gnt, eg);
        check({tag, ".gnt_vld"}, {7'd0, gnt_vld}, {7'd0, |eg});
        check({tag, ".sel"}, {5'd0, sel}, {5'd0, es});
        check({tag, ".preempt"}, {7'd0, preempt}, {7'd0, ep});
        check({tag, ".onehot"}, {7'd0, $onehot0(gnt) && (gnt_vld == |gnt)}, 8'd1);
    endtask

    task automatic step(input string tag, input logic [7:0] r, input logic [7:0] eg,
                        input logic [2:0] es, input logic ep);
        req = r;
        @(posedge clk);
        #1;
        check_outs(tag, eg, es, ep);
    endtask

    function automatic void add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                                input logic p);
        vec_t v;
        v.req = r;
        v.gnt = g;
        v.sel = s;
        v.pre = p;
        vecs.push_back(v);
    endfunction

    initial begin
        n_asrt = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = 8'h00;

        // Single requester held, with a preempt when the timeout is built in.
        for (int j = 0; j < 6; j++) begin
            if (TO_EN && j == 4) add(8'h01, 8'h00, 3'd0, 1'b1);
            else                 add(8'h01, 8'h01, 3'd0, 1'b0);
        end
        add(8'h00, 8'h00, 3'd0, 1'b0);
        add(8'h00, 8'h00, 3'd0, 1'b0);
        // Park ptr at 7 so the full rotation starts at 0.
        add(8'h80, 8'h80, 3'd7, 1'b0);
        add(8'h00, 8'h00, 3'd7, 1'b0);
        for (int k = 0; k < 9; k++) begin
            logic [2:0] o;
            logic [7:0] oh;
            o  = 3'(k % 8);
            oh = 8'd1 << o;
            add(8'hFF, oh, o, 1'b0);
            add(8'hFF, oh, o, 1'b0);
            add(8'hFF, oh, o, 1'b0);
            add(8'hFF & ~oh, 8'h00, o, 1'b0);
        end
        // Wrap-around both ways.
        add(8'h80, 8'h80, 3'd7, 1'b0);
        add(8'h00, 8'h00, 3'd7, 1'b0);
        add(8'h81, 8'h01, 3'd0, 1'b0);
        add(8'h81, 8'h01, 3'd0, 1'b0);
        add(8'h80, 8'h00, 3'd0, 1'b0);
        add(8'h81, 8'h80, 3'd7, 1'b0);
        add(8'h81, 8'h80, 3'd7, 1'b0);
        add(8'h00, 8'h00, 3'd7, 1'b0);
        // Owner 3 ignores other request changes; next IDLE arbitration wins 5.
        add(8'h08, 8'h08, 3'd3, 1'b0);
        add(8'h28, 8'h08, 3'd3, 1'b0);
        add(8'h68, 8'h08, 3'd3, 1'b0);
        add(8'h48, 8'h08, 3'd3, 1'b0);
        add(8'h60, 8'h00, 3'd3, 1'b0);
        add(8'h60, 8'h20, 3'd5, 1'b0);
        add(8'h00, 8'h00, 3'd5, 1'b0);

        #12;
        check_outs("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt, vecs[i].sel, vecs[i].pre);
        end

        // Asynchronous reset mid-grant of owner 4.
        step("own4", 8'h10, 8'h10, 3'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 8'h11, 8'h01, 3'd0, 1'b0);
        step("post_rst_rel", 8'h00, 8'h00, 3'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        step("to1_0", 8'h06, 8'h02, 3'd1, 1'b0);
        for (int j = 0; j < 3; j++) step("to1_h", 8'h06, 8'h02, 3'd1, 1'b0);
        step("to1_pre", 8'h06, 8'h00, 3'd1, 1'b1);
        step("to2_0", 8'h06, 8'h04, 3'd2, 1'b0);
        for (int j = 0; j < 3; j++) step("to2_h", 8'h06, 8'h04, 3'd2, 1'b0);
        step("to2_pre", 8'h06, 8'h00, 3'd2, 1'b1);
        step("to1_again", 8'h06, 8'h02, 3'd1, 1'b0);
        for (int j = 0; j < 3; j++) step("sole_h", 8'h02, 8'h02, 3'd1, 1'b0);
        step("sole_pre", 8'h02, 8'h00, 3'd1, 1'b1);
        step("sole_regnt", 8'h02, 8'h02, 3'd1, 1'b0);
        step("sole_rel", 8'h00, 8'h00, 3'd1, 1'b0);
`else
        for (int j = 0; j < 20; j++) step("unbounded", 8'h02, 8'h02, 3'd1, 1'b0);
        step("unbounded_rel", 8'h00, 8'h00, 3'd1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
